pulse_ring_counter: RTL
=======================

# pulse_ring_counter

Parametrised ring state machine that steps through `NSTATES` states on input pulses. It counts up or down, accepts a synchronous load, and flags a programmable terminal state. It drives the board LED bank from user push-buttons or switch pulses in the lab top level. It can optionally synchronise and edge-detect a raw asynchronous button input internally.

## Interface
- `NSTATES`, 4: number of ring states; legal range 2..256.
- `TERM`, `NSTATES-1`: terminal state index that drives `match`; must be < `NSTATES`.
- `W` (localparam), `$clog2(NSTATES)`: width of the state index.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `pulse` in 1: step request (see Configuration for how it is sampled).
- `dir` in 1: 0 = count up, 1 = count down; sampled on the same edge as the step.
- `load` in 1: synchronous load request.
- `load_val` in W: state to load.
- `state` out W: current state index (registered).
- `led` out NSTATES: one-hot decode of `state`; `led[state]` = 1.
- `match` out 1: 1 while `state == TERM`.
- `wrap` out 1: registered single-cycle strobe on ring wrap.
- `err` out 1: sticky flag; set by an illegal load.

## Operation
- Reset values: `state` = 0, `led` = 1 (bit 0 set), `match` = (`TERM` == 0), `wrap` = 0, `err` = 0. All internal sync/edge registers are 0.
- Priority on each edge: `load` > `step` > hold.
- Load:
  - If `load_val` < `NSTATES`, then `state` <= `load_val` and `wrap` <= 0.
  - If `load_val` >= `NSTATES`, `state` holds and `err` <= 1.
  - A step requested in the same cycle as a load is dropped.
- Step, up (`dir` = 0): `state` <= `state`+1. From `NSTATES-1` it goes to 0 and sets `wrap` <= 1.
- Step, down (`dir` = 1): `state` <= `state`-1. From 0 it goes to `NSTATES-1` and sets `wrap` <= 1.
- Arithmetic uses the compare-and-wrap rule above, not a power-of-two rollover. This applies for any `NSTATES`, including non-powers-of-two.
- `wrap` is 0 on every edge that does not perform a wrapping step.
- Hold: `state` unchanged, `wrap` <= 0.
- `err` clears only on `rst`.
- `led` and `match` are purely combinational decodes of the registered `state`; no extra latency.

## Timing
- Load: `state` updates on the first rising edge with `load` = 1.
- Step without the macro: `state` updates on the first rising edge with `pulse` = 1.
- Step with the macro: a `pulse` rising edge first seen at edge k updates `state` at edge k+2.
- `wrap` is high for exactly the one cycle following the wrapping edge.
- Reset mid-operation: asynchronous assertion forces all reset values immediately. Any pulse in flight in the synchroniser is discarded. The first edge after `rst` deasserts performs no step unless `pulse` qualifies anew.

## Configuration
- Macro: `PULSE_SYNC_EN`.
- Defined:
  - `pulse` is treated as asynchronous.
  - It passes through a 2-flop synchroniser (s1, s2) and a third delay flop s3.
  - step = s2 & ~s3, so exactly one step is taken per low-to-high transition, regardless of how long `pulse` stays high.
- Undefined:
  - No synchroniser.
  - step = `pulse`, so the ring advances once per clock edge for every cycle `pulse` is high (level-sensitive).
  - `pulse` must be synchronous to `clk`.

## Test plan
- Step up, wrap: `NSTATES`=4, macro off, 4 single-cycle pulses, `dir`=0.
  - `state` goes 1,2,3,0 and `led` goes 0010,0100,1000,0001.
  - `match` is high only at state 3.
  - `wrap` is high for exactly 1 cycle after the 4th pulse.
- Down count, non-power-of-two: `NSTATES`=5, `dir`=1, pulse from reset.
  - `state` = 4 and `wrap` pulses once.
  - A second pulse gives `state` = 3.
- Load priority and error: `NSTATES`=5.
  - `load`=1 with `load_val`=2 and `pulse`=1 together gives `state`=2 (no step).
  - A later `load_val`=6 leaves `state`=2 and sets `err`=1.
  - `err` stays 1 until `rst`.
- Edge detect: macro on, `pulse` held high for 10 cycles.
  - Exactly one step occurs; `state` goes 0 to 1 at the 3rd edge after the rise.
  - Macro off with the same stimulus: `state` advances 10 times (ends at 2 for `NSTATES`=4).
- Reset mid-flight: macro on, assert `rst` one cycle after the `pulse` rise.
  - After release, `state` = 0, `wrap` = 0, `led` = 0001.
  - No step occurs, because the pulse is lost.
- Terminal config: `TERM`=0, `NSTATES`=8.
  - `match` = 1 out of reset.
  - `match` = 0 after one up-pulse, and 1 again after 8 total pulses.

Source files
------------

// File: rtl/pulse_ring_counter.sv
// pulse_ring_counter: up/down ring index with synchronous load, terminal-state
// match, single-cycle wrap strobe and sticky illegal-load error.
// Optional macro PULSE_SYNC_EN: treat pulse as asynchronous, pass it through a
// 2-flop synchroniser plus a delay flop, and step once per rising edge.
// Without the macro, every clock edge with pulse high takes one step.
//
// state | meaning
// ------+---------------------------------------------
// 0..N-1| ring position; led is its one-hot decode
// TERM  | terminal position, match asserted
module pulse_ring_counter #(
   parameter int NSTATES = 4,
   parameter int TERM    = NSTATES - 1,
   localparam int W      = $clog2(NSTATES)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pulse,
   input  logic               dir,
   input  logic               load,
   input  logic [W-1:0]       load_val,
   output logic [W-1:0]       state,
   output logic [NSTATES-1:0] led,
   output logic               match,
   output logic               wrap,
   output logic               err
);

   localparam logic [W-1:0]       LAST     = W'(NSTATES - 1);
   localparam logic [W-1:0]       TERM_IDX = W'(TERM);
   localparam logic [NSTATES-1:0] LED0     = NSTATES'(1);

   logic         step;
   logic         load_ok;
   logic [W-1:0] state_nxt;
   logic         wrap_nxt;
   logic         err_nxt;

`ifdef PULSE_SYNC_EN
   logic s1, s2, s3;

   // Synchronise the raw pulse and keep one extra delayed copy for edge detect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= pulse;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign step = s2 & ~s3;
`else
   assign step = pulse;
`endif

   // A power-of-two ring accepts every encodable load value
   generate
      if ((1 << W) == NSTATES) begin : g_load_pow2
         assign load_ok = 1'b1;
      end else begin : g_load_cmp
         localparam logic [W:0] NS_LIM = NSTATES[W:0];
         assign load_ok = ({1'b0, load_val} < NS_LIM);
      end
   endgenerate

   // Next ring position: load beats step beats hold; wrap by compare, not rollover
   always_comb begin
      state_nxt = state;
      wrap_nxt  = 1'b0;
      err_nxt   = err;
      if (load) begin
         if (load_ok) begin
            state_nxt = load_val;
         end else begin
            err_nxt = 1'b1;
         end
      end else if (step) begin
         if (!dir) begin
            if (state == LAST) begin
               state_nxt = '0;
               wrap_nxt  = 1'b1;
            end else begin
               state_nxt = state + 1'b1;
            end
         end else begin
            if (state == '0) begin
               state_nxt = LAST;
               wrap_nxt  = 1'b1;
            end else begin
               state_nxt = state - 1'b1;
            end
         end
      end
   end

   // Ring position, wrap strobe and sticky error registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= '0;
         wrap  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         wrap  <= wrap_nxt;
         err   <= err_nxt;
      end
   end

   assign led   = LED0 << state;
   assign match = (state == TERM_IDX);

endmodule
